kmeans_mem_arbiter: RTL

//  Owns the single-port sample SRAM of the k-means engine. Sequences the load phase:
//  the in_valid/in_data stream fills addresses 0..N_WORDS-1. Then arbitrates SRAM

---
 rtl/kmeans_mem_arbiter_if.sv | 53 +++++
 rtl/kmeans_mem_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/kmeans_mem_arbiter_if.sv
// Bundle of the k-means sample-SRAM arbiter: load stream, two requesters, SRAM bus.
// Handshake: r*_req (with addr/we/wdata) is held until r*_gnt is high in the same cycle; that cycle is the transfer; a read returns one r*_rvalid pulse two cycles after the grant.
interface kmeans_mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              load_done;

  logic              r0_req;
  logic [ADDR_W-1:0] r0_addr;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  clear, in_valid, in_data,
    input  r0_req, r0_addr,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output load_done,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output clear, in_valid, in_data,
    output r0_req, r0_addr,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  load_done,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/kmeans_mem_arbiter.sv
// Sample-SRAM owner: sequential load of N_WORDS, then R0/R1 arbitration (round-robin).
// Define KMEANS_ARB_FIXED_PRIO_EN to make R1 always win a conflict instead.
module kmeans_mem_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int N_WORDS = 4096
) (
  input  logic                clk,
  input  logic                rst,
  kmeans_mem_arbiter_if.slave bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_LAST  = 2'd2,
    ST_SERVE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic              load_wr;
  logic              gnt0, gnt1;

  logic              mem_cs_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd0_s1, rd1_s1;
  logic              r0_rvalid_q, r1_rvalid_q;
  logic [DATA_W-1:0] r0_hold, r1_hold;

`ifndef KMEANS_ARB_FIXED_PRIO_EN
  logic              rr_last;  // 0: R0 granted last, 1: R1 granted last
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ST_LAST covers the cycle the final load word is on the SRAM bus, so
  // serving (and load_done) begins only once that write has been issued.
  always_comb begin
    state_nxt = state;
    load_wr   = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (bus.clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (bus.in_valid) begin
            load_wr   = 1'b1;
            state_nxt = (wptr == LAST_ADDR) ? ST_LAST : ST_LOAD;
          end
        end
        ST_LAST: state_nxt = ST_SERVE;
        ST_SERVE: begin
          if (bus.r0_req && bus.r1_req) begin
`ifdef KMEANS_ARB_FIXED_PRIO_EN
            gnt1 = 1'b1;
`else
            gnt0 = rr_last;
            gnt1 = ~rr_last;
`endif
          end else begin
            gnt0 = bus.r0_req;
            gnt1 = bus.r1_req;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

`ifndef KMEANS_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_last <= 1'b1;
    else if (bus.clear) rr_last <= 1'b1;
    else if (gnt0)      rr_last <= 1'b0;
    else if (gnt1)      rr_last <= 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd0_s1      <= 1'b0;
      rd1_s1      <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else if (bus.clear) begin
      wptr        <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rd0_s1      <= 1'b0;
      rd1_s1      <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      mem_cs_q <= load_wr | gnt0 | gnt1;
      mem_we_q <= load_wr | (gnt1 & bus.r1_we);
      if (load_wr) begin
        mem_addr_q  <= wptr;
        mem_wdata_q <= bus.in_data;
        wptr        <= wptr + 1'b1;
      end else if (gnt0) begin
        mem_addr_q  <= bus.r0_addr;
      end else if (gnt1) begin
        mem_addr_q  <= bus.r1_addr;
        mem_wdata_q <= bus.r1_wdata;
      end
      // Two-stage read tag: SRAM cycle, then the cycle its data is returned.
      rd0_s1      <= gnt0;
      rd1_s1      <= gnt1 & ~bus.r1_we;
      r0_rvalid_q <= rd0_s1;
      r1_rvalid_q <= rd1_s1;
    end
  end

  // Read data passes straight through on the rvalid cycle and is held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_hold <= '0;
      r1_hold <= '0;
    end else begin
      if (r0_rvalid_q) r0_hold <= bus.mem_rdata;
      if (r1_rvalid_q) r1_hold <= bus.mem_rdata;
    end
  end

  assign bus.load_done = (state == ST_SERVE);
  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = r0_rvalid_q;
  assign bus.r1_rvalid = r1_rvalid_q;
  assign bus.r0_rdata  = r0_rvalid_q ? bus.mem_rdata : r0_hold;
  assign bus.r1_rdata  = r1_rvalid_q ? bus.mem_rdata : r1_hold;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign state_dbg     = state;

endmodule
